// File: rtl/lcd_cmd_sequencer.sv
// Custom-instruction sequencer for an HD44780-style 8-bit character LCD.
// Performs timed single writes, the power-on init script, and a status query.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | bus parked, waiting for an accepted start
// PWR_WAIT | power-up delay before the first init command
// SETUP    | RS/data driven, enable low
// PULSE    | enable high
// HOLD     | enable low again, RS/data still held
// EXEC     | waiting for the LCD to finish the command
// NEXT     | advance the init script or finish it
// DONE     | one-cycle done pulse with result
module lcd_cmd_sequencer #(
  parameter int T_SETUP     = 4,
  parameter int T_PW        = 12,
  parameter int T_HOLD      = 4,
  parameter int T_EXEC      = 2500,
  parameter int T_EXEC_LONG = 82000,
  parameter int T_POWERUP   = 750000,
  parameter int CNT_W       = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_enable,
  output logic [7:0]  lcd_data
);

  typedef enum logic [2:0] {
    IDLE, PWR_WAIT, SETUP, PULSE, HOLD, EXEC, NEXT, DONE
  } state_t;

  localparam logic [CNT_W-1:0] LD_SETUP     = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PW        = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] LD_HOLD      = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_EXEC      = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] LD_EXEC_LONG = CNT_W'(T_EXEC_LONG - 1);
  localparam logic [CNT_W-1:0] LD_POWERUP   = CNT_W'(T_POWERUP - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       step;
  logic             init_active;
  logic             init_done;
  logic             pre_init_write;
  logic             exec_long;
  logic             unused_bits;

  assign lcd_rw      = 1'b0;
  assign unused_bits = ^{dataa[31:9], datab[31:2]};

  // Clear and return-home are the only slow HD44780 instructions.
  assign exec_long = !lcd_rs && (lcd_data[7:2] == 6'd0);

  function automatic logic [7:0] script_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    script_byte = 8'h38;
      2'd1:    script_byte = 8'h0C;
      2'd2:    script_byte = 8'h06;
      default: script_byte = 8'h01;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      step           <= 2'd0;
      init_active    <= 1'b0;
      init_done      <= 1'b0;
      pre_init_write <= 1'b0;
      done           <= 1'b0;
      result         <= 32'd0;
      lcd_rs         <= 1'b0;
      lcd_enable     <= 1'b0;
      lcd_data       <= 8'd0;
    end else if (clk_en) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (datab[1:0])
              2'd0: begin
                lcd_rs   <= dataa[8];
                lcd_data <= dataa[7:0];
                if (!init_done) pre_init_write <= 1'b1;
                cnt      <= LD_SETUP;
                state    <= SETUP;
              end
              2'd1: begin
                step           <= 2'd0;
                init_done      <= 1'b0;
                pre_init_write <= 1'b0;
                init_active    <= 1'b1;
                cnt            <= LD_POWERUP;
                state          <= PWR_WAIT;
              end
              default: begin
                done   <= 1'b1;
                result <= {30'd0, pre_init_write, init_done};
                state  <= DONE;
              end
            endcase
          end
        end
        PWR_WAIT: begin
          if (cnt == '0) begin
            lcd_rs   <= 1'b0;
            lcd_data <= script_byte(2'd0);
            cnt      <= LD_SETUP;
            state    <= SETUP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            lcd_enable <= 1'b1;
            cnt        <= LD_PW;
            state      <= PULSE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            lcd_enable <= 1'b0;
            cnt        <= LD_HOLD;
            state      <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            cnt   <= exec_long ? LD_EXEC_LONG : LD_EXEC;
            state <= EXEC;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            if (init_active) begin
              state <= NEXT;
            end else begin
              done   <= 1'b1;
              result <= {23'd0, lcd_rs, lcd_data};
              state  <= DONE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        NEXT: begin
          if (step == 2'd3) begin
            init_done   <= 1'b1;
            init_active <= 1'b0;
            done        <= 1'b1;
            result      <= 32'd1;
            state       <= DONE;
          end else begin
            step     <= step + 2'd1;
            lcd_rs   <= 1'b0;
            lcd_data <= script_byte(step + 2'd1);
            cnt      <= LD_SETUP;
            state    <= SETUP;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed bench for lcd_cmd_sequencer with shortened timing parameters.
// Cycle c is sampled on the c-th falling edge after the start is driven.
module tb_lcd_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic        done;
  logic [31:0] result;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_enable;
  logic [7:0]  lcd_data;

  always #5 clk = ~clk;

  lcd_cmd_sequencer #(
    .T_SETUP(2), .T_PW(3), .T_HOLD(2), .T_EXEC(5),
    .T_EXEC_LONG(20), .T_POWERUP(10), .CNT_W(20)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
    .dataa(dataa), .datab(datab), .done(done), .result(result),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_enable(lcd_enable),
    .lcd_data(lcd_data)
  );

  int          checks = 0;
  int          errors = 0;
  int          done_cyc, done_cnt, en_first, en_high, en_rises;
  logic [31:0] res_done;
  logic [7:0]  pbyte [4];
  logic        prs_any;
  logic [7:0]  data_c1;
  logic        rs_c1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit extra,
                        input int freeze_at, input int limit);
    logic prev_en;
    prev_en  = lcd_enable;
    done_cyc = 0; done_cnt = 0; en_first = 0; en_high = 0; en_rises = 0;
    res_done = '0; prs_any = 1'b0; data_c1 = '0; rs_c1 = 1'b0;
    for (int i = 0; i < 4; i++) pbyte[i] = '0;
    dataa  = a;
    datab  = b;
    clk_en = 1'b1;
    start  = 1'b1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) begin
        data_c1 = lcd_data;
        rs_c1   = lcd_rs;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = c;
          res_done = result;
        end
      end
      if (lcd_enable) begin
        en_high++;
        if (!prev_en) begin
          if (en_rises == 0) en_first = c;
          if (en_rises < 4) pbyte[en_rises] = lcd_data;
          prs_any = prs_any | lcd_rs;
          en_rises++;
        end
      end
      prev_en = lcd_enable;
      if (extra && (c == 2 || c == 10)) start = 1'b1;
      clk_en = !(freeze_at != 0 && c >= freeze_at && c < freeze_at + 4);
      if (done_cyc != 0 && c >= done_cyc + 3) break;
    end
    clk_en = 1'b1;
    start  = 1'b0;
  endtask

  initial begin
    int dn;
    reset  = 1'b0;
    clk_en = 1'b1;
    start  = 1'b0;
    dataa  = '0;
    datab  = '0;
    repeat (3) @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_en", lcd_enable, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_data", lcd_data, 0);
    chk("rst_rw", lcd_rw, 0);
    reset = 1'b1;
    @(negedge clk);

    run_op(32'h141, 32'd0, 1'b0, 0, 60);
    chk("wr_data_c1", data_c1, 8'h41);
    chk("wr_rs_c1", rs_c1, 1);
    chk("wr_en_first", en_first, 3);
    chk("wr_en_high", en_high, 3);
    chk("wr_done_cyc", done_cyc, 13);
    chk("wr_done_cnt", done_cnt, 1);
    chk("wr_result", res_done, 32'h141);
    chk("wr_rw", lcd_rw, 0);

    run_op(32'h0, 32'd2, 1'b0, 0, 20);
    chk("st_pre_done_cyc", done_cyc, 1);
    chk("st_pre_result", res_done, 32'h2);

    run_op(32'h001, 32'd0, 1'b0, 0, 60);
    chk("clr_done_cyc", done_cyc, 28);
    chk("clr_result", res_done, 32'h001);

    run_op(32'h003, 32'd0, 1'b0, 0, 60);
    chk("home_done_cyc", done_cyc, 28);

    run_op(32'h004, 32'd0, 1'b0, 0, 60);
    chk("b04_done_cyc", done_cyc, 13);

    run_op(32'h101, 32'd0, 1'b0, 0, 60);
    chk("rs1_done_cyc", done_cyc, 13);
    chk("rs1_result", res_done, 32'h101);

    run_op(32'h0, 32'd1, 1'b0, 0, 150);
    chk("init_en_first", en_first, 13);
    chk("init_rises", en_rises, 4);
    chk("init_en_high", en_high, 12);
    chk("init_b0", pbyte[0], 8'h38);
    chk("init_b1", pbyte[1], 8'h0C);
    chk("init_b2", pbyte[2], 8'h06);
    chk("init_b3", pbyte[3], 8'h01);
    chk("init_rs", prs_any, 0);
    chk("init_done_cyc", done_cyc, 78);
    chk("init_done_cnt", done_cnt, 1);
    chk("init_result", res_done, 32'h1);

    run_op(32'h0, 32'd3, 1'b0, 0, 20);
    chk("st_init_done_cyc", done_cyc, 1);
    chk("st_init_result", res_done, 32'h1);

    run_op(32'h141, 32'd0, 1'b1, 3, 80);
    chk("frz_en_first", en_first, 3);
    chk("frz_en_high", en_high, 7);
    chk("frz_done_cyc", done_cyc, 17);
    chk("frz_done_cnt", done_cnt, 1);
    chk("frz_result", res_done, 32'h141);

    dn     = 0;
    dataa  = '0;
    datab  = 32'd1;
    start  = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) dn++;
    end
    chk("abort_pre_en", lcd_enable, 1);
    chk("abort_pre_data", lcd_data, 8'h06);
    #2 reset = 1'b0;
    #1;
    chk("abort_en", lcd_enable, 0);
    chk("abort_data", lcd_data, 0);
    chk("abort_rs", lcd_rs, 0);
    chk("abort_result", result, 0);
    repeat (3) begin
      @(negedge clk);
      if (done) dn++;
    end
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", dn, 0);

    run_op(32'h0, 32'd2, 1'b0, 0, 20);
    chk("st_abort_done_cyc", done_cyc, 1);
    chk("st_abort_result", res_done, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
